plate_controller: RTL and testbench



---
 rtl/plate_controller.sv | 163 ++++++++++++++++
 tb/tb_plate_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/plate_controller.sv
// Button sequencer for the plate paddle: synchronizes and debounces the buttons, then issues
// tick-aligned single-cycle move codes with hold-to-repeat and step boost.
module plate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 3,
  parameter int unsigned BOOST_AFTER     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fast,
  output logic [3:0] control,
  output logic       moving
);

  localparam int unsigned TMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam int unsigned RW   = $clog2(BOOST_AFTER + 1);
  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StFirst, StDelay, StRepeat} state_e;
  typedef enum logic [1:0] {DirNone = 2'b00, DirRight = 2'b01, DirLeft = 2'b10} dir_e;

  // Bit 0 = left, bit 1 = right, bit 2 = fast.
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1, r_sync2, r_db;
  logic [DW-1:0] r_dbcnt [3];

  state_e        r_state, w_state_d;
  dir_e          r_dir, w_dir_d, w_req;
  logic [TW-1:0] r_tcnt, w_tcnt_d, w_tcnt_inc;
  logic [RW-1:0] r_rcnt, w_rcnt_d;
  logic [3:0]    r_control, w_control_d;
  logic          r_moving;
  logic          w_move, w_abort, w_step2;

  assign w_raw = {btn_fast, btn_right, btn_left};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < 3; i++) r_dbcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]    <= r_sync2[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    w_req = DirNone;
    if (r_db[0] && !r_db[1]) w_req = DirLeft;
    else if (r_db[1] && !r_db[0]) w_req = DirRight;
  end

  assign w_tcnt_inc = r_tcnt + TW'(1);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_dir     <= DirNone;
      r_tcnt    <= '0;
      r_rcnt    <= '0;
      r_control <= 4'b1111;
      r_moving  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_dir     <= w_dir_d;
      r_tcnt    <= w_tcnt_d;
      r_rcnt    <= w_rcnt_d;
      r_control <= w_control_d;
      r_moving  <= (w_state_d != StIdle);
    end
  end

  // Next-state logic; abort outranks any tick in the same cycle.
  always_comb begin
    w_state_d = r_state;
    w_dir_d   = r_dir;
    w_tcnt_d  = r_tcnt;
    w_rcnt_d  = r_rcnt;
    w_move    = 1'b0;
    w_abort   = (r_state != StIdle) && (!enable || (w_req != r_dir));
    if (w_abort) begin
      w_state_d = StIdle;
      w_tcnt_d  = '0;
      w_rcnt_d  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_tcnt_d = '0;
          w_rcnt_d = '0;
          if (enable && (w_req != DirNone)) begin
            w_dir_d   = w_req;
            w_state_d = StFirst;
          end
        end
        StFirst: begin
          if (tick) begin
            w_move    = 1'b1;
            w_tcnt_d  = '0;
            w_rcnt_d  = '0;
            w_state_d = StDelay;
          end
        end
        StDelay: begin
          if (tick) begin
            if (w_tcnt_inc == TW'(REPEAT_DELAY)) begin
              w_move    = 1'b1;
              w_tcnt_d  = '0;
              w_rcnt_d  = RW'(1);
              w_state_d = StRepeat;
            end else begin
              w_tcnt_d = w_tcnt_inc;
            end
          end
        end
        StRepeat: begin
          if (tick) begin
            if (w_tcnt_inc == TW'(REPEAT_PERIOD)) begin
              w_move   = 1'b1;
              w_tcnt_d = '0;
              w_rcnt_d = (r_rcnt == RW'(BOOST_AFTER)) ? r_rcnt : r_rcnt + RW'(1);
            end else begin
              w_tcnt_d = w_tcnt_inc;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Output logic; step size uses the repeat count belonging to this move.
  always_comb begin
    w_step2     = r_db[2] || (w_rcnt_d >= RW'(BOOST_AFTER));
    w_control_d = 4'b1111;
    if (w_move) begin
      if (r_dir == DirLeft) w_control_d = w_step2 ? 4'b0110 : 4'b0100;
      else                  w_control_d = w_step2 ? 4'b0011 : 4'b0001;
    end
  end

  assign control = r_control;
  assign moving  = r_moving;

endmodule

// File: tb/tb_plate_controller.sv
// Scoreboard bench for plate_controller: expected control/moving per cycle derived from
// press timing, tick counts and the repeat schedule.
module tb_plate_controller;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam int BA = 4;
  localparam int Never = 1 << 30;

  logic       clock = 1'b0;
  logic       reset, tick, enable, btn_left, btn_right, btn_fast;
  logic [3:0] control;
  logic       moving;

  always #5 clock = ~clock;

  plate_controller #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .BOOST_AFTER    (BA)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .enable   (enable),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_fast (btn_fast),
    .control  (control),
    .moving   (moving)
  );

  typedef struct packed {
    logic [3:0] code;
    logic       mov;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         act_from = -1;   // first cycle whose tick the FSM may use
  int         act_until = Never; // first cycle in which the abort fires
  int         tick_idx = 0;
  bit         m_left, m_fast;
  logic [3:0] last_code = 4'b1111;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b, want %b", tag, cyc, obs, exp);
  endtask

  // Tick k after FIRST entry: k=0 first move, k=RD first repeat, then every RP ticks.
  function automatic logic [3:0] move_code(input int k, input bit left, input bit fast);
    bit mv = 1'b0;
    int rep = 0;
    bit step2;
    if (k == 0) mv = 1'b1;
    else if (k >= RD && ((k - RD) % RP) == 0) begin
      mv  = 1'b1;
      rep = (k - RD) / RP + 1;
    end
    if (!mv) return 4'b1111;
    step2 = fast || (rep >= BA);
    if (left) return step2 ? 4'b0110 : 4'b0100;
    return step2 ? 4'b0011 : 4'b0001;
  endfunction

  task automatic run_cycle();
    exp_t e;
    bit   active;
    tick   = (cyc % 4 == 0);
    active = (act_from >= 0) && (cyc >= act_from) && (cyc < act_until);
    e.code = 4'b1111;
    if (active && tick) begin
      e.code = move_code(tick_idx, m_left, m_fast);
      tick_idx++;
    end
    e.mov = (act_from >= 0) && (cyc + 1 >= act_from) && (cyc + 1 <= act_until);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    last_code = e.code;
    check_eq("control", control, e.code);
    check_eq("moving", {3'b000, moving}, {3'b000, e.mov});
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic press(input bit l, input bit r, input bit f);
    btn_left  = l;
    btn_right = r;
    btn_fast  = f;
    act_from  = cyc + 2 + DB + 1;
    act_until = Never;
    tick_idx  = 0;
    m_left    = l;
    m_fast    = f;
  endtask

  task automatic release_all();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_fast  = 1'b0;
    if (act_until > cyc + 2 + DB) act_until = cyc + 2 + DB;
  endtask

  task automatic run_to_idx(input int target);
    for (int g = 0; g < 400 && tick_idx < target; g++) run_cycle();
  endtask

  task automatic align_tick(input int offset);
    for (int g = 0; g < 4 && ((cyc + offset) % 4) != 0; g++) run_cycle();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_fast = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_control", control, 4'b1111);
    check_eq("reset_moving", {3'b000, moving}, 4'b0000);
    reset = 1'b0;
    run(8);

    // Single left press: first move, delay, repeats, boost.
    press(1'b1, 1'b0, 1'b0);
    run(130);
    release_all();
    run(20);

    // Right with fast held: every move at step 2.
    press(1'b0, 1'b1, 1'b1);
    run(70);
    release_all();
    run(20);

    // Bouncing left never qualifies.
    act_from = -1;
    for (int i = 0; i < 10; i++) begin
      btn_left = ~btn_left;
      run(2);
    end
    btn_left = 1'b0;
    run(20);

    // Both pressed during DELAY, abort lands on a tick; then release left.
    press(1'b1, 1'b0, 1'b0);
    run_to_idx(3);
    align_tick(2 + DB);
    btn_right = 1'b1;
    act_until = cyc + 2 + DB;
    run(20);
    btn_left  = 1'b0;
    act_from  = cyc + 2 + DB + 1;
    act_until = Never;
    tick_idx  = 0;
    m_left    = 1'b0;
    m_fast    = 1'b0;
    run(30);
    release_all();
    run(20);

    // Enable dropped in REPEAT, raised again with left still held.
    press(1'b1, 1'b0, 1'b0);
    run_to_idx(RD + 2);
    align_tick(0);
    enable    = 1'b0;
    act_until = cyc;
    run(10);
    align_tick(0);
    enable    = 1'b1;
    act_from  = cyc + 1;
    act_until = Never;
    tick_idx  = 0;
    run(50);

    // Reset while a repeat move is on control.
    for (int g = 0; g < 400 && !(tick_idx > RD + 2 * RP && last_code != 4'b1111); g++)
      run_cycle();
    reset = 1'b1;
    #1;
    check_eq("midreset_control", control, 4'b1111);
    check_eq("midreset_moving", {3'b000, moving}, 4'b0000);
    #1;
    reset     = 1'b0;
    act_from  = cyc + 2 + DB + 1;
    act_until = Never;
    tick_idx  = 0;
    run(50);
    release_all();
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
